uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among NREQ byte requesters.
- Sits between the requesters (loopback echo, status reporters, debug dumpers) and the UART block's TX_VALID/TX_DATA/TX_READY port.
- Selects one requester per byte using round-robin priority and latches that byte.
- Presents the byte to the UART and holds it until the UART accepts it.
- With packet locking compiled in, keeps the grant on one requester until it marks the last byte of a packet.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among NREQ byte requesters. Picks
//            one requester per byte by round-robin, latches its byte, and
//            holds it on TX_DATA until the UART accepts it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NREQ      number of requesters (2..8)
//   TIMEOUT   stall cycles before a packet lock is dropped (lock build only)
// Ports
//   SCLK       in   system clock, rising edge
//   RESET      in   synchronous active-high reset
//   REQ_VALID  in   [NREQ]    requester i has a byte
//   REQ_DATA   in   [8*NREQ]  byte of requester i at [8i+7:8i]
//   REQ_LAST   in   [NREQ]    byte of requester i ends its packet
//   REQ_READY  out  [NREQ]    one-cycle pulse: byte of requester i taken
//   TX_VALID   out            byte on TX_DATA is pending for the UART
//   TX_DATA    out  [8]       byte to send
//   TX_READY   in             UART can accept a byte
//   GRANT      out  [NREQ]    one-hot current/last owner, 0 when none
//   BUSY       out            arbiter is not idle
// Build option
//   UART_ARB_LOCK_EN : when defined, the grant stays on one requester until
//   it presents a byte with REQ_LAST set (or stalls TIMEOUT cycles).
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                SCLK,
  input  logic                RESET,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [8*NREQ-1:0]   REQ_DATA,
  input  logic [NREQ-1:0]     REQ_LAST,
  output logic [NREQ-1:0]     REQ_READY,
  output logic                TX_VALID,
  output logic [7:0]          TX_DATA,
  input  logic                TX_READY,
  output logic [NREQ-1:0]     GRANT,
  output logic                BUSY
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
`ifdef UART_ARB_LOCK_EN
  localparam logic [1:0] S_LOCKED = 2'd3;
  localparam int         SW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
`endif

  logic [1:0]      r_state;
  logic [PW-1:0]   r_ptr;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  logic [NREQ-1:0] r_grant;
`ifdef UART_ARB_LOCK_EN
  logic            r_last;
  logic [SW-1:0]   r_stall;
`else
  // Packet marking and the timeout only matter in the lock build.
  logic            w_unused;
  assign w_unused = ^{REQ_LAST, (TIMEOUT > 0)};
`endif

  logic            w_rr_found;
  logic [PW-1:0]   w_rr_idx;
  logic [PW-1:0]   w_cand;
  logic [PW-1:0]   w_sel;
  logic            w_load;
  logic [NREQ-1:0] w_onehot;

  // Round-robin search: first valid requester after r_ptr, wrapping, so the
  // most recent owner is checked last.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_rr_found && REQ_VALID[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  // Load decision: any winner from IDLE, or only the owner while locked.
  always_comb begin
    w_sel  = w_rr_idx;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: w_load = w_rr_found;
`ifdef UART_ARB_LOCK_EN
      S_LOCKED: begin
        w_sel  = r_ptr;
        w_load = REQ_VALID[r_ptr];
      end
`endif
      default: w_load = 1'b0;
    endcase
  end

  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  // Gated by RESET so a byte is never acknowledged on a cycle that discards it.
  assign REQ_READY = (w_load && !RESET) ? w_onehot : '0;
  assign TX_VALID  = r_tx_valid;
  assign TX_DATA   = r_tx_data;
  assign GRANT     = r_grant;
  assign BUSY      = (r_state != S_IDLE);

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_ptr      <= PW'(NREQ - 1);
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant    <= '0;
`ifdef UART_ARB_LOCK_EN
      r_last     <= 1'b0;
      r_stall    <= '0;
`endif
    end else begin
      if (w_load) begin
        r_tx_data  <= REQ_DATA[{w_sel, 3'b000} +: 8];
        r_tx_valid <= 1'b1;
        r_grant    <= w_onehot;
        r_ptr      <= w_sel;
`ifdef UART_ARB_LOCK_EN
        r_last     <= REQ_LAST[w_sel];
        r_stall    <= '0;
`endif
        r_state    <= S_SEND;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_SEND: begin
            if (r_tx_valid && TX_READY) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_GAP;
            end
          end
          // One dead cycle covers the UART's TX_READY drop after a transfer.
          S_GAP: begin
`ifdef UART_ARB_LOCK_EN
            if (!r_last) begin
              r_stall <= '0;
              r_state <= S_LOCKED;
            end else begin
              r_grant <= '0;
              r_state <= S_IDLE;
            end
`else
            r_grant <= '0;
            r_state <= S_IDLE;
`endif
          end
`ifdef UART_ARB_LOCK_EN
          // Owner has no byte: count the stall; on expiry release the lock.
          // r_ptr stays on the stalled owner, giving it lowest priority.
          S_LOCKED: begin
            if (r_stall == SW'(TIMEOUT - 1)) begin
              r_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_stall <= r_stall + 1'b1;
            end
          end
`endif
          default: begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter: directed scenarios plus
//            a randomized run scored against a packet-level queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .SCLK(clk), .RESET(rst),
    .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_LAST(req_last),
    .REQ_READY(req_ready),
    .TX_VALID(tx_valid), .TX_DATA(tx_data), .TX_READY(tx_ready),
    .GRANT(grant), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        sb_en = 1'b0;
  logic [15:0] exp_q[$];    // {requester index, byte}
  logic [15:0] mon_e;
  int          n_rdy  = 0;
  int          n_xfer = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (req_ready != '0) begin
        n_rdy++;
        chk("rdy_onehot", 32'($onehot(req_ready)), 1);
        chk("rdy_while_txvalid", 32'(tx_valid), 0);
      end
      if (tx_valid && tx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) chk("sb_unexpected_byte", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("sb_data", 32'(tx_data), 32'(mon_e[7:0]));
          chk("sb_grant", 32'(grant), 32'(4'b0001 << mon_e[15:8]));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [7:0]      src_d [NREQ][16];
  logic            src_l [NREQ][16];
  int              src_len[NREQ];
  int              pos[NREQ];
  logic [NREQ-1:0] rdy_s;
  logic            xfer;
  int              exp_g[6];

  initial begin
    int n, last_r, first_c, n2, k, ptr, w, total, cyc, hold;
    logic stable, done;
    logic [NREQ-1:0] first_v, first_g;

    // ---- reset values ----
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);

    // ---- single byte from requester 0 ----
    tick();
    rst = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = '1; tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_tx_valid_decide", 32'(tx_valid), 0);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("t1_tx_valid", 32'(tx_valid), 1);
    chk("t1_tx_data", 32'(tx_data), 32'h41);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy_send", 32'(busy), 1);
    chk("t1_ready_send", 32'(req_ready), 0);
    tick(); tx_ready = 1'b0;
    @(negedge clk);
    chk("t1_gap_tx_valid", 32'(tx_valid), 0);
    chk("t1_gap_busy", 32'(busy), 1);
    tick(); tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_grant", 32'(grant), 0);

    // ---- strict rotation, all valid, TX_READY high ----
    do_reset();
    req_valid = 4'b1111; req_data = 32'h40302010; req_last = '1; tx_ready = 1'b1;
    n = 0; last_r = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        chk("t2_rot_data", 32'(tx_data), 32'(8'h10 * (1 + (n % 4))));
        n++;
      end
      if (req_ready != '0) begin
        if (last_r >= 0) chk("t2_spacing", 32'(c - last_r), 3);
        last_r = c;
      end
    end
    chk("t2_xfer_count", 32'(n), 13);

    // ---- TX_READY low for 50 cycles during SEND ----
    do_reset();
    req_valid = 4'b0100; req_data[23:16] = 8'h5A; req_last = '1; tx_ready = 1'b0;
    @(negedge clk);
    chk("t3_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'h5A && req_ready == '0 && busy && grant == 4'b0100))
        stable = 1'b0;
    end
    chk("t3_stable", 32'(stable), 1);
    tick(); tx_ready = 1'b1;
    @(negedge clk);
    chk("t3_xfer_valid", 32'(tx_valid), 1);
    tick(); tx_ready = 1'b0;
    @(negedge clk);
    chk("t3_after_xfer", 32'(tx_valid), 0);

    // ---- reset during SEND ----
    do_reset();
    req_valid = 4'b0110; req_last = '1; tx_ready = 1'b0;
    @(negedge clk);
    chk("t4_first", 32'(req_ready), 32'h2);
    tick(); rst = 1'b1; req_valid = 4'b0101;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t4_tx_valid", 32'(tx_valid), 0);
    chk("t4_grant", 32'(grant), 0);
    chk("t4_restart_r0", 32'(req_ready), 32'h1);

    // ---- packet of 3 from requester 2 vs constantly valid requester 0 ----
`ifdef UART_ARB_LOCK_EN
    exp_g = '{0, 2, 2, 2, 0, 0};
`else
    exp_g = '{0, 2, 0, 2, 0, 2};
`endif
    do_reset();
    n2 = 0;
    req_valid = 4'b0101; req_data[7:0] = 8'h0F; req_last[0] = 1'b1;
    req_data[23:16] = 8'hA0; req_last[2] = 1'b0; tx_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      @(negedge clk);
      rdy_s = req_ready;
      if (tx_valid && tx_ready) begin
        chk("t5_owner", 32'(grant), 32'(4'b0001 << exp_g[k]));
        k++;
      end
      tick();
      if (rdy_s[2]) n2++;
      req_data[23:16] = 8'hA0 + 8'(n2);
      req_last[2]     = (n2 == 2);
      req_valid[2]    = (n2 < 3);
    end
    chk("t5_count", 32'(k), 6);

    // ---- owner 1 stalls after a non-last byte, requester 3 waiting ----
    do_reset();
    req_valid = 4'b1010; req_last = '0; tx_ready = 1'b1;
    first_c = -1; first_v = '0; first_g = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rdy_s = req_ready;
      if (c == 0) chk("t6_first_owner", 32'(rdy_s), 32'h2);
      else if (rdy_s != '0 && first_c < 0) begin
        first_c = c; first_v = rdy_s; first_g = grant;
      end
      tick();
      if (rdy_s[1]) req_valid[1] = 1'b0;
    end
`ifdef UART_ARB_LOCK_EN
    chk("t6_release_cycle", 32'(first_c), 32'(3 + TMO));
`else
    chk("t6_release_cycle", 32'(first_c), 3);
`endif
    chk("t6_winner", 32'(first_v), 32'h8);
    chk("t6_grant_cleared", 32'(first_g), 0);

    // ---- randomized run against the queue model ----
    do_reset();
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      src_len[i] = $urandom_range(1, 12);
      total += src_len[i];
      for (int j = 0; j < 16; j++) begin
        src_d[i][j] = 8'($urandom);
        src_l[i][j] = ($urandom_range(0, 2) == 0) || (j == src_len[i] - 1);
      end
      pos[i] = 0;
    end
    // Model: round-robin over requesters that still hold bytes; in the lock
    // build a winner keeps sending until it emits a byte marked last.
    ptr = NREQ - 1;
    while (1) begin
      w = -1;
      for (int d = 1; d <= NREQ; d++)
        if (w < 0 && pos[(ptr + d) % NREQ] < src_len[(ptr + d) % NREQ]) w = (ptr + d) % NREQ;
      if (w < 0) break;
      done = 1'b0;
      while (!done) begin
        exp_q.push_back({8'(w), src_d[w][pos[w]]});
`ifdef UART_ARB_LOCK_EN
        done = src_l[w][pos[w]] || (pos[w] + 1 >= src_len[w]);
`else
        done = 1'b1;
`endif
        pos[w]++;
      end
      ptr = w;
    end
    for (int i = 0; i < NREQ; i++) pos[i] = 0;
    n_rdy = 0; n_xfer = 0; hold = 0; cyc = 0;
    tx_ready = 1'b1;
    sb_en = 1'b1;
    while (cyc < 20000 && exp_q.size() != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pos[i] < src_len[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = src_d[i][pos[i]];
          req_last[i] = src_l[i][pos[i]];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
      @(negedge clk);
      rdy_s = req_ready;
      xfer  = tx_valid && tx_ready;
      tick();
      for (int i = 0; i < NREQ; i++) if (rdy_s[i]) pos[i]++;
      if (xfer) hold = $urandom_range(1, 6);
      if (hold > 0) begin
        tx_ready = 1'b0;
        hold--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
      cyc++;
    end
    repeat (2) @(negedge clk);
    sb_en = 1'b0;
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_ready_pulses", 32'(n_rdy), 32'(total));
    chk("rand_transfers", 32'(n_xfer), 32'(total));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
